mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port of the multicycle MIPS
//  core between two requesters: the core and a program loader/debug port.
//  Sits between the core datapath memory interface and the memory array.
//  Stalls the core (core_stall gates PCen/IRWrite in the core top) while the loader owns the port.
//  Fixed loader priority, with a starvation guard that forces a core grant.
// PARAMETERS
//  WIDTH     32  data and address width
//  MAX_WAIT  4   max consecutive stalled core cycles before the core is forced a grant
//                (0 = core always wins)
//  CNT_W     16  width of stall statistics counter (ARB_STATS_EN only)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  c_req      in   1      core access request
//  c_we       in   1      core write enable
//  c_addr     in   WIDTH  core address
//  c_wd       in   WIDTH  core write data
//  c_gnt      out  1      core owns port this cycle
//  c_rd       out  WIDTH  read data to core (= mem_rd)
//  core_stall out  1      c_req & ~c_gnt
//  l_req      in   1      loader access request
//  l_we       in   1      loader write enable
//  l_lock     in   1      loader requests to keep ownership on the next cycle
//  l_addr     in   WIDTH  loader address
//  l_wd       in   WIDTH  loader write data
//  l_gnt      out  1      loader owns port this cycle
//  l_rd       out  WIDTH  read data to loader (= mem_rd)
//  mem_addr   out  WIDTH  memory address
//  mem_wd     out  WIDTH  memory write data
//  mem_we     out  1      memory write enable
//  mem_rd     in   WIDTH  memory read data (combinational read)
// BEHAVIOUR
//  - State register owner in {IDLE, CORE, LOAD}. c_gnt = (owner==CORE); l_gnt = (owner==LOAD).
//  - Next owner is evaluated every clock, in priority order:
//    1. c_req & wait_cnt==MAX_WAIT -> CORE (starvation guard; overrides l_lock)
//    2. owner==LOAD & l_req & l_lock -> LOAD
//    3. l_req -> LOAD
//    4. c_req -> CORE
//    5. else -> IDLE
//  - wait_cnt: +1 (saturating at MAX_WAIT) each cycle with c_req & ~c_gnt; cleared on any c_gnt cycle.
//  - Latency: request seen at edge N is granted in cycle N+1. An uncontended held request is granted every cycle.
//  - Access completes at the end of a cycle with gnt=1 and req=1. The requester holds req/we/addr/wd stable until then.
//  - Mux: mem_addr/mem_wd select the owner's inputs; in IDLE they are 0.
//    mem_we = owner_we & owner_req & ~rst. A dropped req during grant gives no write.
//  - c_rd = l_rd = mem_rd, unregistered; valid in the grant cycle.
//  - Simultaneous c_req & l_req: the loader wins until the guard fires. The guard then gives
//    exactly one CORE cycle, after which the loader is re-granted if still requesting.
//  - Reset: owner=IDLE, wait_cnt=0. c_gnt = l_gnt = mem_we = 0; mem_addr = mem_wd = 0.
//    core_stall = c_req after reset.
//  - Reset mid-access: mem_we is forced 0 during the rst cycle and the in-flight access is dropped.
//    The requester must re-request.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    - Adds input stat_clr and output stall_cnt[CNT_W-1:0].
//    - stall_cnt +1 every cycle core_stall=1 and saturates at all-ones.
//    - stall_cnt is cleared by rst or stat_clr; stat_clr wins over an increment in the same cycle.
//  ARB_STATS_EN undefined: stat_clr and stall_cnt are absent, with no counter logic.
// TESTING
//  1. rst=1 for 2 cycles, all reqs 0 -> c_gnt = l_gnt = mem_we = 0, mem_addr = 0, core_stall = 0.
//  2. c_req=1, c_addr=0x10 held for 3 cycles, l_req=0 -> c_gnt=1 from the 2nd cycle on;
//     core_stall=1 only in the 1st cycle; mem_addr=0x10.
//  3. c_req = l_req = 1 held, MAX_WAIT=4 -> l_gnt for 4 cycles, c_gnt for 1 cycle, then l_gnt again;
//     the pattern repeats.
//  4. Loader write l_we=1, l_addr=0x20, l_wd=0xDEADBEEF while c_req=1 -> one-cycle mem_we=1,
//     mem_addr=0x20, mem_wd=0xDEADBEEF; core_stall=1 in that cycle.
//  5. rst pulsed in a LOAD cycle with l_we=1 -> mem_we=0 in that cycle; owner=IDLE on the next cycle.
//  6. ARB_STATS_EN, 5 stalled core cycles -> stall_cnt=5; stat_clr=1 -> 0 on the next cycle;
//     CNT_W=4 with 20 stalled cycles -> stall_cnt=15.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory port: loader has priority,
// a starvation guard forces a core grant. Define ARB_STATS_EN to add the stall counter.
module mem_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0] c_wd,
  output logic             c_gnt,
  output logic [WIDTH-1:0] c_rd,
  output logic             core_stall,
  input  logic             l_req,
  input  logic             l_we,
  input  logic             l_lock,
  input  logic [WIDTH-1:0] l_addr,
  input  logic [WIDTH-1:0] l_wd,
  output logic             l_gnt,
  output logic [WIDTH-1:0] l_rd,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
`ifdef ARB_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  input  logic [WIDTH-1:0] mem_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CORE = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [1:0]    owner_reg, owner_next;
  logic [WW-1:0] wait_reg, wait_next;
  logic          guard;
  logic          sel_req, sel_we;

  assign c_gnt      = (owner_reg == CORE);
  assign l_gnt      = (owner_reg == LOAD);
  assign core_stall = c_req & ~c_gnt;

  // wait_next already counts this cycle's stall, so the core never waits more than
  // MAX_WAIT consecutive cycles; with MAX_WAIT=0 it stays 0 and the guard always fires.
  always_comb begin
    wait_next = wait_reg;
    if (c_gnt)
      wait_next = '0;
    else if (c_req && (wait_reg != WAIT_MAX))
      wait_next = wait_reg + 1'b1;
  end

  assign guard = c_req && (wait_next == WAIT_MAX);

  always_comb begin
    owner_next = IDLE;
    if (guard)
      owner_next = CORE;
    else if ((owner_reg == LOAD) && l_req && l_lock)
      owner_next = LOAD;
    else if (l_req)
      owner_next = LOAD;
    else if (c_req)
      owner_next = CORE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg <= IDLE;
      wait_reg  <= '0;
    end else begin
      owner_reg <= owner_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    sel_req  = 1'b0;
    sel_we   = 1'b0;
    case (owner_reg)
      CORE: begin
        mem_addr = c_addr;
        mem_wd   = c_wd;
        sel_req  = c_req;
        sel_we   = c_we;
      end
      LOAD: begin
        mem_addr = l_addr;
        mem_wd   = l_wd;
        sel_req  = l_req;
        sel_we   = l_we;
      end
      default: ;
    endcase
  end

  // A requester that drops req in its grant cycle gets no write; reset kills any write.
  assign mem_we = sel_we & sel_req & ~rst;

  assign c_rd = mem_rd;
  assign l_rd = mem_rd;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || stat_clr)
      stall_cnt_reg <= '0;
    else if (core_stall && !(&stall_cnt_reg))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares. Stall-counter checks are active with ARB_STATS_EN.
module tb_mem_port_arbiter;
  localparam logic [31:0] RD_XOR = 32'hA5A5_0000;
`ifdef ARB_STATS_EN
  localparam int CW = 4;
`endif

  logic        clk = 1'b0;
  logic        rst, c_req, c_we, l_req, l_we, l_lock;
  logic [31:0] c_addr, c_wd, l_addr, l_wd;
  logic        c_gnt, l_gnt, core_stall, mem_we;
  logic [31:0] c_rd, l_rd, mem_addr, mem_wd, mem_rd;
`ifdef ARB_STATS_EN
  logic          stat_clr;
  logic [CW-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  assign mem_rd = mem_addr ^ RD_XOR;

  mem_port_arbiter #(
    .WIDTH(32),
    .MAX_WAIT(4)
`ifdef ARB_STATS_EN
    ,
    .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rd(c_rd), .core_stall(core_stall),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wd(l_wd),
    .l_gnt(l_gnt), .l_rd(l_rd),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
`ifdef ARB_STATS_EN
    .stat_clr(stat_clr), .stall_cnt(stall_cnt),
`endif
    .mem_rd(mem_rd)
  );

  typedef struct {
    string       nm;
    logic [3:0]  flags;  // {c_gnt, l_gnt, core_stall, mem_we}
    logic [31:0] addr;
    logic [31:0] wd;
    logic [15:0] sc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sc_model = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Caller drives inputs at the start of a cycle; this records that cycle's expectation
  // and advances to the start of the next cycle.
  task automatic cyc(input string nm, input logic cg, input logic lg, input logic st,
                     input logic we, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    e.nm    = nm;
    e.flags = {cg, lg, st, we};
    e.addr  = addr;
    e.wd    = wd;
    e.sc    = sc_model[15:0];
    sb.push_back(e);
`ifdef ARB_STATS_EN
    if (rst || stat_clr)
      sc_model = 0;
    else if (st && sc_model != (1 << CW) - 1)
      sc_model = sc_model + 1;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("[%0t] %s c_gnt=%b l_gnt=%b stall=%b we=%b addr=%h wd=%h", $time, e.nm,
                 c_gnt, l_gnt, core_stall, mem_we, mem_addr, mem_wd);
        chk(e.nm, "flags", {28'd0, c_gnt, l_gnt, core_stall, mem_we}, {28'd0, e.flags});
        chk(e.nm, "mem_addr", mem_addr, e.addr);
        chk(e.nm, "mem_wd", mem_wd, e.wd);
        chk(e.nm, "c_rd", c_rd, e.addr ^ RD_XOR);
        chk(e.nm, "l_rd", l_rd, e.addr ^ RD_XOR);
`ifdef ARB_STATS_EN
        chk(e.nm, "stall_cnt", {28'd0, stall_cnt}, {16'd0, e.sc});
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wd = '0;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    @(posedge clk);
    #1;

    // Reset state
    cyc("rst1", 0, 0, 0, 0, 32'h0, 32'h0);
    cyc("rst2", 0, 0, 0, 0, 32'h0, 32'h0);

    // Uncontended core request: one stall cycle, then granted every cycle
    rst = 1'b0; c_req = 1'b1; c_addr = 32'h10; c_wd = 32'h55;
    cyc("core_req", 0, 0, 1, 0, 32'h0, 32'h0);
    cyc("core_g1", 1, 0, 0, 0, 32'h10, 32'h55);
    cyc("core_g2", 1, 0, 0, 0, 32'h10, 32'h55);
    c_req = 1'b0; c_we = 1'b1;
    cyc("core_drop_nowr", 1, 0, 0, 0, 32'h10, 32'h55);
    c_we = 1'b0;
    cyc("idle_a", 0, 0, 0, 0, 32'h0, 32'h0);

    // Contention: loader 4 cycles, core 1 cycle, repeating
    l_req = 1'b1; l_lock = 1'b1; l_addr = 32'h30; l_wd = 32'h77;
    cyc("ld_first", 0, 0, 0, 0, 32'h0, 32'h0);
    c_req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k % 5 == 4) cyc("guard_core", 1, 0, 0, 0, 32'h10, 32'h55);
      else            cyc("lock_load", 0, 1, 1, 0, 32'h30, 32'h77);
    end
    c_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
    cyc("ld_tail", 0, 1, 0, 0, 32'h30, 32'h77);
    cyc("idle_b", 0, 0, 0, 0, 32'h0, 32'h0);

    // Loader write while the core waits
    c_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wd = 32'hDEADBEEF;
    cyc("lw_req", 0, 0, 1, 0, 32'h0, 32'h0);
    cyc("lw_write", 0, 1, 1, 1, 32'h20, 32'hDEADBEEF);
    l_req = 1'b0; l_we = 1'b0;
    cyc("lw_regrant_norq", 0, 1, 1, 0, 32'h20, 32'hDEADBEEF);
    c_we = 1'b1; c_wd = 32'h1234;
    cyc("core_write", 1, 0, 0, 1, 32'h10, 32'h1234);
    c_req = 1'b0;
    cyc("core_tail", 1, 0, 0, 0, 32'h10, 32'h1234);
    c_we = 1'b0;
    cyc("idle_c", 0, 0, 0, 0, 32'h0, 32'h0);

    // Reset during a loader write
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h40; l_wd = 32'h99;
    cyc("rw_req", 0, 0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    cyc("rw_rst", 0, 1, 0, 0, 32'h40, 32'h99);
    rst = 1'b0;
    cyc("rw_after_rst", 0, 0, 0, 0, 32'h0, 32'h0);
    cyc("rw_rewrite", 0, 1, 0, 1, 32'h40, 32'h99);
    l_req = 1'b0;
    cyc("rw_tail", 0, 1, 0, 0, 32'h40, 32'h99);
    l_we = 1'b0;
    cyc("idle_d", 0, 0, 0, 0, 32'h0, 32'h0);

`ifdef ARB_STATS_EN
    // Stall counter: clear, count, clear mid-stall, saturate at 15
    stat_clr = 1'b1;
    cyc("st_clr0", 0, 0, 0, 0, 32'h0, 32'h0);
    stat_clr = 1'b0; l_req = 1'b1; l_addr = 32'h30; l_wd = 32'h77;
    cyc("st_ld_first", 0, 0, 0, 0, 32'h0, 32'h0);
    c_req = 1'b1;
    for (int k = 0; k < 36; k++) begin
      stat_clr = (k == 7);
      if (k % 5 == 4) cyc("st_core", 1, 0, 0, 0, 32'h10, 32'h55);
      else            cyc("st_load", 0, 1, 1, 0, 32'h30, 32'h77);
    end
    stat_clr = 1'b0; c_req = 1'b0; l_req = 1'b0;
    cyc("st_tail", 0, 1, 0, 0, 32'h30, 32'h77);
    cyc("st_idle", 0, 0, 0, 0, 32'h0, 32'h0);
`endif

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
